// File: rtl/ofdm_src_pkg.sv
// Shared definitions for the OFDM serial bit source: mode encodings,
// controller states and PRBS7 polynomial constants/helpers.
package ofdm_src_pkg;

    // Mode input encoding (value 3 is reserved and runs as PATTERN)
    localparam logic [1:0] MODE_PATTERN = 2'd0;
    localparam logic [1:0] MODE_STREAM  = 2'd1;
    localparam logic [1:0] MODE_PRBS    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    // PRBS7, polynomial x^7 + x^6 + 1
    localparam int PRBS7_W     = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    // One LFSR step: shift left, feed back the XOR of the two taps
    function automatic logic [PRBS7_W-1:0] prbs7_step(input logic [PRBS7_W-1:0] cur);
        return {cur[PRBS7_W-2:0], cur[PRBS7_TAP_A] ^ cur[PRBS7_TAP_B]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [PRBS7_W-1:0] prbs7_legal_seed(input logic [PRBS7_W-1:0] seed);
        return (seed == 7'h00) ? 7'h01 : seed;
    endfunction

endpackage

// File: rtl/ofdm_prbs7.sv
// 7-bit Fibonacci LFSR (x^7 + x^6 + 1) used by the bit source PRBS mode.
// bit_now is the bit currently presented; bit_next is the bit that will be
// presented after the next advance.
module ofdm_prbs7
    import ofdm_src_pkg::*;
#(
    parameter logic [PRBS7_W-1:0] SEED = 7'h7F
) (
    input  logic clk_half,
    input  logic reset,
    input  logic advance,
    output logic bit_now,
    output logic bit_next
);

    localparam logic [PRBS7_W-1:0] SEED_EFF = prbs7_legal_seed(SEED);

    logic [PRBS7_W-1:0] lfsr_r;

    // LFSR register: reload seed on reset, step once per consumed bit
    always_ff @(posedge clk_half) begin
        if (reset) begin
            lfsr_r <= SEED_EFF;
        end else if (advance) begin
            lfsr_r <= prbs7_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign bit_now  = lfsr_r[PRBS7_TAP_A];
    assign bit_next = lfsr_r[PRBS7_TAP_B];

endmodule

// File: rtl/ofdm_bit_source.sv
// Serial bit source for the OFDM modulator x_in input. Emits a registered,
// LSB-first valid/ready bit stream from a loadable pattern, a streamed word
// interface, or a PRBS7 generator, with a start-of-symbol flag every
// SYM_BITS bits. The PRBS mode exists only when OFDM_SRC_PRBS_EN is defined;
// otherwise mode 2 runs as PATTERN.
module ofdm_bit_source
    import ofdm_src_pkg::*;
#(
    parameter int                 DATA_W    = 4,
    parameter int                 SYM_BITS  = 8,
    parameter logic [DATA_W-1:0]  PAT_INIT  = DATA_W'(4'b0110),
    parameter logic [PRBS7_W-1:0] PRBS_SEED = 7'h7F
) (
    input  logic              clk_half,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] pat_in,
    input  logic              pat_load,
    input  logic [DATA_W-1:0] s_word,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              sof,
    output logic              busy,
    output logic              underrun
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int SYM_W = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_BITS - 1);
    localparam logic [SYM_W-1:0] SYM_ZERO = {SYM_W{1'b0}};

    state_t            state_r,     state_nx_s;
    logic [1:0]        mode_r,      mode_nx_s;
    logic [DATA_W-1:0] pattern_r,   pattern_nx_s;
    logic [DATA_W-1:0] word_r,      word_nx_s;
    logic [IDX_W-1:0]  idx_r,       idx_nx_s;
    logic [SYM_W-1:0]  sym_cnt_r,   sym_cnt_nx_s;
    logic              bit_out_r,   bit_out_nx_s;
    logic              bit_valid_r, bit_valid_nx_s;
    logic              sof_r,       sof_nx_s;
    logic              underrun_r,  underrun_nx_s;
    logic              busy_r;

    logic [1:0]        mode_eff_s;
    logic [DATA_W-1:0] pat_start_s;
    logic [IDX_W-1:0]  idx_inc_s;
    logic [SYM_W-1:0]  sym_adv_s;
    logic              consume_s;
    logic              last_bit_s;
    logic              s_ready_s;
    logic              accept_s;
    logic              prbs_bit_s;
    logic              prbs_next_s;

`ifdef OFDM_SRC_PRBS_EN
    logic prbs_adv_s;

    assign prbs_adv_s = consume_s && (mode_r == MODE_PRBS);

    ofdm_prbs7 #(
        .SEED (PRBS_SEED)
    ) u_prbs7 (
        .clk_half (clk_half),
        .reset    (reset),
        .advance  (prbs_adv_s),
        .bit_now  (prbs_bit_s),
        .bit_next (prbs_next_s)
    );

    // Map the mode input onto the modes this build supports
    always_comb begin
        mode_eff_s = MODE_PATTERN;
        case (mode)
            MODE_STREAM: mode_eff_s = MODE_STREAM;
            MODE_PRBS:   mode_eff_s = MODE_PRBS;
            default:     mode_eff_s = MODE_PATTERN;
        endcase
    end
`else
    logic unused_seed_s;

    assign prbs_bit_s    = 1'b0;
    assign prbs_next_s   = 1'b0;
    assign unused_seed_s = ^PRBS_SEED;

    // Map the mode input onto the modes this build supports (no PRBS)
    always_comb begin
        mode_eff_s = MODE_PATTERN;
        case (mode)
            MODE_STREAM: mode_eff_s = MODE_STREAM;
            default:     mode_eff_s = MODE_PATTERN;
        endcase
    end
`endif

    assign consume_s   = bit_valid_r && bit_ready;
    assign last_bit_s  = (idx_r == IDX_LAST);
    assign idx_inc_s   = last_bit_s ? IDX_ZERO : (idx_r + 1'b1);
    assign sym_adv_s   = consume_s ? ((sym_cnt_r == SYM_LAST) ? SYM_ZERO : (sym_cnt_r + 1'b1))
                                   : sym_cnt_r;
    assign pat_start_s = pat_load ? pat_in : pattern_r;
    assign s_ready_s   = (state_r == ST_RUN) && (mode_r == MODE_STREAM) &&
                         (!bit_valid_r || (consume_s && last_bit_s));
    assign accept_s    = s_ready_s && s_valid;

    // Next-state and next-output logic for the controller and bit datapath
    always_comb begin
        state_nx_s     = state_r;
        mode_nx_s      = mode_r;
        pattern_nx_s   = pattern_r;
        word_nx_s      = word_r;
        idx_nx_s       = idx_r;
        sym_cnt_nx_s   = sym_cnt_r;
        bit_out_nx_s   = bit_out_r;
        bit_valid_nx_s = bit_valid_r;
        sof_nx_s       = sof_r;
        underrun_nx_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                bit_out_nx_s   = 1'b0;
                bit_valid_nx_s = 1'b0;
                sof_nx_s       = 1'b0;
                if (pat_load) begin
                    pattern_nx_s = pat_in;
                end else begin
                    pattern_nx_s = pattern_r;
                end
                if (start && !stop) begin
                    state_nx_s   = ST_RUN;
                    mode_nx_s    = mode_eff_s;
                    idx_nx_s     = IDX_ZERO;
                    sym_cnt_nx_s = SYM_ZERO;
                    case (mode_eff_s)
                        MODE_STREAM: begin
                            bit_valid_nx_s = 1'b0;
                        end
                        MODE_PRBS: begin
                            bit_out_nx_s   = prbs_bit_s;
                            bit_valid_nx_s = 1'b1;
                            sof_nx_s       = 1'b1;
                        end
                        default: begin
                            bit_out_nx_s   = pat_start_s[0];
                            bit_valid_nx_s = 1'b1;
                            sof_nx_s       = 1'b1;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (consume_s) begin
                    sym_cnt_nx_s = sym_adv_s;
                    sof_nx_s     = (sym_adv_s == SYM_ZERO);
                    idx_nx_s     = idx_inc_s;
                    case (mode_r)
                        MODE_STREAM: begin
                            if (!last_bit_s) begin
                                bit_out_nx_s = word_r[idx_inc_s];
                            end else if (accept_s) begin
                                word_nx_s    = s_word;
                                bit_out_nx_s = s_word[0];
                            end else begin
                                // Starved: drop valid, keep the symbol phase running
                                bit_out_nx_s   = 1'b0;
                                bit_valid_nx_s = 1'b0;
                                sof_nx_s       = 1'b0;
                                underrun_nx_s  = (state_r == ST_RUN);
                            end
                        end
                        MODE_PRBS: begin
                            bit_out_nx_s = prbs_next_s;
                        end
                        default: begin
                            bit_out_nx_s = pattern_r[idx_inc_s];
                        end
                    endcase
                end else if (accept_s) begin
                    // Empty shift register refilled; first bit keeps the current phase
                    word_nx_s      = s_word;
                    idx_nx_s       = IDX_ZERO;
                    bit_out_nx_s   = s_word[0];
                    bit_valid_nx_s = 1'b1;
                    sof_nx_s       = (sym_cnt_r == SYM_ZERO);
                end else begin
                    word_nx_s = word_r;
                end

                if (state_r == ST_RUN) begin
                    if (stop) begin
                        state_nx_s = ST_STOPPING;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else if (!bit_valid_r || (consume_s && last_bit_s)) begin
                    state_nx_s     = ST_IDLE;
                    idx_nx_s       = IDX_ZERO;
                    bit_out_nx_s   = 1'b0;
                    bit_valid_nx_s = 1'b0;
                    sof_nx_s       = 1'b0;
                end else begin
                    state_nx_s = ST_STOPPING;
                end
            end

            default: begin
                state_nx_s     = ST_IDLE;
                bit_out_nx_s   = 1'b0;
                bit_valid_nx_s = 1'b0;
                sof_nx_s       = 1'b0;
            end
        endcase
    end

    // Register all state and outputs; reset aborts any run immediately
    always_ff @(posedge clk_half) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_PATTERN;
            pattern_r   <= PAT_INIT;
            word_r      <= {DATA_W{1'b0}};
            idx_r       <= IDX_ZERO;
            sym_cnt_r   <= SYM_ZERO;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            sof_r       <= 1'b0;
            underrun_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            mode_r      <= mode_nx_s;
            pattern_r   <= pattern_nx_s;
            word_r      <= word_nx_s;
            idx_r       <= idx_nx_s;
            sym_cnt_r   <= sym_cnt_nx_s;
            bit_out_r   <= bit_out_nx_s;
            bit_valid_r <= bit_valid_nx_s;
            sof_r       <= sof_nx_s;
            underrun_r  <= underrun_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    assign s_ready   = s_ready_s;
    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;
    assign sof       = sof_r;
    assign busy      = busy_r;
    assign underrun  = underrun_r;

endmodule
